cmatmul2x2_ctrl: RTL
====================

# cmatmul2x2_ctrl

Sequencer that computes the 2x2 complex matrix product C = A·B on one shared complex multiply-accumulate unit of the same form as the team's single complex multiplier (re = ar·br − ai·bi, im = ar·bi + ai·br). The block accepts the eight input elements over a valid/ready stream, issues one complex product per cycle, accumulates pairs, and returns the four results over a second valid/ready stream. It sits between an element-streaming front end and any downstream consumer of complex results.

## Interface
- DW, default 8: element component width, signed two's complement.
- RW, fixed at 2*DW+2 (18 at the default width): result component width, signed. Not overridable.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  element presented.
- in_ready  output  1  block accepts an element this cycle.
- in_re, in_im  input  DW each  element real/imaginary part.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- out_re, out_im  output  RW each  result real/imaginary part.
- abort  input  1  synchronous return to IDLE.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, COMPUTE, OUTPUT.
- Reset values: state IDLE, all element registers 0, accumulator 0, result registers 0.
- Reset output values: in_ready=1, out_valid=0, out_re=0, out_im=0, busy=0.
- Element transfer: occurs on any clock edge where in_valid and in_ready are both 1.
- Load order: A00, A01, A10, A11, B00, B01, B10, B11 (row-major, A first).
- IDLE: in_ready=1. The first transfer stores A00 and moves to LOAD.
- LOAD: in_ready=1. A 3-bit load index counts transfers. The transfer that stores B11 moves to COMPUTE.
- COMPUTE: in_ready=0. Runs exactly 8 cycles, one complex product per cycle.
  - Product order is (i,j,k) with k fastest: (0,0,0), (0,0,1), (0,1,0), … (1,1,1).
  - Each cycle computes p = A[i][k]·B[k][j].
  - k=0: accumulator ← p.
  - k=1: C[i][j] ← accumulator + p, stored in the result register bank.
  - After the 8th cycle, move to OUTPUT.
- Arithmetic width rules:
  - Each partial product is sign-extended to RW before add/subtract.
  - re = ar·br − ai·bi, im = ar·bi + ai·br.
  - RW bits hold the full range, so no overflow is possible. Worst case: DW=8, all components −128, im = 4·16384 = 65536 < 2^17.
- OUTPUT: out_valid=1. Results are presented in the order C00, C01, C10, C11.
  - out_re/out_im stay stable while out_valid=1 and out_ready=0.
  - Each edge with out_valid and out_ready both 1 advances to the next result.
  - Acceptance of C11 returns the block to IDLE. out_valid drops on the next cycle.
  - out_re/out_im hold their last value when out_valid=0.
- abort: when high at an edge, state becomes IDLE and all indices clear.
  - Element and result registers are not cleared.
  - abort has priority over any simultaneous input or output handshake; that handshake is discarded.
- Reset mid-operation: immediate return to reset values, whatever the state.
- in_valid while in_ready=0: ignored, no error. out_ready while out_valid=0: ignored.

## Timing
- Input side sustains one element per cycle: 8 back-to-back transfers on edges E1..E8.
- After the B11 transfer at E8:
  - COMPUTE occupies the cycles following edges E8..E15.
  - out_valid rises after edge E16, i.e. 8 cycles after the last input transfer.
- Output side sustains one result per cycle. With out_ready held high, the four results take 4 cycles.
- Minimum period for a full operation: 8 load + 8 compute + 4 output = 20 cycles.
- in_ready rises the cycle after C11 is accepted. Input and output phases never overlap.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- Identity check: A = I (1+0j diagonal), B = [[1+2j, 3−4j], [−5+6j, 7+8j]] with out_ready=1.
  - Required: outputs exactly B in the order C00..C11.
  - Required: out_valid first high 8 cycles after the B11 transfer.
- Full-scale check: all 16 input components −128 (DW=8).
  - Required: every C element has re=0 and im=65536. No wrap.
- Output backpressure: hold out_ready=0 for 5 cycles on C01, then release.
  - Required: C01 held stable throughout, then C10 and C11 follow.
- Input gaps and blocking: insert random in_valid gaps during LOAD.
  - Required: results match a golden model.
  - Required: in_valid pulses during COMPUTE are not consumed (in_ready=0).
- abort mid-operation: assert abort after 5 loads, then stream a fresh operation.
  - Required: busy falls the next cycle.
  - Required: the new result is correct, with no stale elements used.
  - Also required: assert abort on the same edge as a C00 handshake → that output is discarded and the block is in IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously during COMPUTE.
  - Required: out_valid=0, in_ready=1, busy=0 and outputs 0 immediately.
  - Required: the next operation completes correctly.

Source files
------------

// File: rtl/cmatmul2x2_ctrl.sv
// 2x2 complex matrix product C = A*B on one shared complex MAC.
// Streams in eight elements, runs eight product cycles, streams out four results.
module cmatmul2x2_ctrl #(
  parameter int DW = 8,
  localparam int RW = 2*DW + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_re,
  output logic [RW-1:0] out_im,
  input  logic          abort,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on valid, and valid never depends on ready.

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t     state, state_nxt;
  logic [2:0] load_idx, comp_idx;
  logic [1:0] out_idx, out_idx_nxt;
  logic       in_fire, out_fire;

  logic signed [DW-1:0] a_re [4];
  logic signed [DW-1:0] a_im [4];
  logic signed [DW-1:0] b_re [4];
  logic signed [DW-1:0] b_im [4];
  logic signed [RW-1:0] c_re [4];
  logic signed [RW-1:0] c_im [4];
  logic signed [RW-1:0] acc_re, acc_im;
  logic [RW-1:0]        out_re_q, out_im_q;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign out_idx_nxt = out_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_fire) state_nxt = LOAD;
        LOAD:    if (in_fire && load_idx == 3'd7) state_nxt = COMPUTE;
        COMPUTE: if (comp_idx == 3'd7) state_nxt = OUTPUT;
        OUTPUT:  if (out_fire && out_idx == 2'd3) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == LOAD);
    out_valid = (state == OUTPUT);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx <= '0;
      comp_idx <= '0;
      out_idx  <= '0;
    end else if (abort) begin
      load_idx <= '0;
      comp_idx <= '0;
      out_idx  <= '0;
    end else begin
      if (in_fire)            load_idx <= load_idx + 3'd1;
      if (state == COMPUTE)   comp_idx <= comp_idx + 3'd1;
      if (out_fire)           out_idx  <= out_idx_nxt;
    end
  end

  // comp_idx = {i, j, k}: A index is {i,k}, B index is {k,j}
  logic [1:0]             a_sel, b_sel, c_sel;
  logic signed [2*DW-1:0] rr, ii, ri, ir;
  logic signed [RW-1:0]   p_re, p_im;

  assign a_sel = {comp_idx[2], comp_idx[0]};
  assign b_sel = {comp_idx[0], comp_idx[1]};
  assign c_sel = {comp_idx[2], comp_idx[1]};
  assign rr    = a_re[a_sel] * b_re[b_sel];
  assign ii    = a_im[a_sel] * b_im[b_sel];
  assign ri    = a_re[a_sel] * b_im[b_sel];
  assign ir    = a_im[a_sel] * b_re[b_sel];
  assign p_re  = {{(RW-2*DW){rr[2*DW-1]}}, rr} - {{(RW-2*DW){ii[2*DW-1]}}, ii};
  assign p_im  = {{(RW-2*DW){ri[2*DW-1]}}, ri} + {{(RW-2*DW){ir[2*DW-1]}}, ir};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        a_re[n] <= '0;
        a_im[n] <= '0;
        b_re[n] <= '0;
        b_im[n] <= '0;
        c_re[n] <= '0;
        c_im[n] <= '0;
      end
      acc_re   <= '0;
      acc_im   <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else if (!abort) begin
      if (in_fire) begin
        if (!load_idx[2]) begin
          a_re[load_idx[1:0]] <= in_re;
          a_im[load_idx[1:0]] <= in_im;
        end else begin
          b_re[load_idx[1:0]] <= in_re;
          b_im[load_idx[1:0]] <= in_im;
        end
      end
      if (state == COMPUTE) begin
        if (!comp_idx[0]) begin
          acc_re <= p_re;
          acc_im <= p_im;
        end else begin
          c_re[c_sel] <= acc_re + p_re;
          c_im[c_sel] <= acc_im + p_im;
        end
      end
      // Output register only moves on entry to OUTPUT and on accepted results
      if (state == COMPUTE && comp_idx == 3'd7) begin
        out_re_q <= c_re[0];
        out_im_q <= c_im[0];
      end else if (out_fire && out_idx != 2'd3) begin
        out_re_q <= c_re[out_idx_nxt];
        out_im_q <= c_im[out_idx_nxt];
      end
    end
  end

  assign out_re = out_re_q;
  assign out_im = out_im_q;

endmodule
